// File: rtl/and4_share_arb_if.sv
// Requester-side handshake bundle for and4_share_arb: two request/operand
// pairs going in, ack/done pulses plus the shared result coming back.
interface and4_share_arb_if;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic       ack0, ack1;
  logic       done0, done1;
  logic       res;
  logic       busy;
  logic       err;

  modport master (
    output req0, req1, data0, data1,
    input  ack0, ack1, done0, done1, res, busy, err
  );

  modport slave (
    input  req0, req1, data0, data1,
    output ack0, ack1, done0, done1, res, busy, err
  );
endinterface

// File: rtl/and4_share_arb.sv
// Round-robin arbiter/sequencer sharing one 4-input AND datapath between two
// requesters. Optional result self-check enabled by defining AND4_ARB_CHECK_EN.
module and4_share_arb #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and4_share_arb_if.slave       bus,
  output logic                  dp_m,
  output logic                  dp_n,
  output logic                  dp_p,
  output logic                  dp_q,
  input  logic                  dp_out
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ptr;
  logic             gsel;
  logic             pick1;

  // Requester 1 wins when it asks alone, or when both ask and the pointer favours it.
  assign pick1 = bus.req1 & (~bus.req0 | ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      gsel      <= 1'b0;
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.res   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
      dp_m      <= 1'b0;
      dp_n      <= 1'b0;
      dp_p      <= 1'b0;
      dp_q      <= 1'b0;
    end else begin
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            if (pick1) begin
              {dp_m, dp_n, dp_p, dp_q} <= bus.data1;
              bus.ack1 <= 1'b1;
              gsel     <= 1'b1;
              ptr      <= 1'b0;
            end else begin
              {dp_m, dp_n, dp_p, dp_q} <= bus.data0;
              bus.ack0 <= 1'b1;
              gsel     <= 1'b0;
              ptr      <= 1'b1;
            end
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          // Operand has been stable for SETTLE_CYCLES periods at this edge.
          if (cnt == CNT_LAST) begin
            bus.res   <= dp_out;
            bus.done0 <= ~gsel;
            bus.done1 <= gsel;
            bus.busy  <= 1'b0;
`ifdef AND4_ARB_CHECK_EN
            bus.err   <= (dp_out != (dp_m & dp_n & dp_p & dp_q));
`else
            bus.err   <= 1'b0;
`endif
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/and4_share_arb.md
# and4_share_arb

Round-robin arbiter and sequencer that shares one instance of the 4-input AND path-delay datapath (inputs m, n, p, q; output out; 12–15 time-unit pin-to-pin delays) between two requesters. It latches the granted operand, drives it onto the datapath, and waits a programmable number of clock cycles so the path delay settles. It then samples the datapath output and returns it to the granted requester with a one-cycle done pulse. It sits between the requesting logic and the shared datapath instance.

## Interface
- SETTLE_CYCLES, 2, clock periods the operand is held before out is sampled; legal range 1..255; must cover the worst path delay (15)
- CNT_W, 8, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0, req1  input  1 each  request; held high with data stable until the matching ack
- data0, data1  input  4 each  operand {m,n,p,q}, MSB = m
- ack0, ack1  output  1 each  one-cycle pulse: request accepted, data latched
- done0, done1  output  1 each  one-cycle pulse: res is valid for that requester
- res  output  1  sampled datapath result; holds until the next sample
- busy  output  1  high while not IDLE
- err  output  1  check-mismatch pulse (see Configuration)
- dp_m, dp_n, dp_p, dp_q  output  1 each  drive the shared datapath inputs
- dp_out  input  1  datapath output

## Operation
- States: IDLE, SETTLE. All outputs are registered.
- IDLE, arbitration:
  - Neither req high: stay in IDLE.
  - One req high: grant it.
  - Both high: grant the requester selected by the pointer ptr.
  - On grant: latch the operand into dp_m..dp_q, pulse ack_k, clear the counter, go to SETTLE, set ptr to the other requester.
  - Single-request grants also move ptr to the other requester.
- SETTLE:
  - Each edge with cnt != SETTLE_CYCLES-1: cnt increments.
  - Edge with cnt == SETTLE_CYCLES-1: res <= dp_out, pulse done_k for the granted requester, return to IDLE.
- dp_m..dp_q keep the last operand after completion and change only on the next grant.
- Requests arriving during SETTLE are not acknowledged. They are arbitrated at the first IDLE edge.
- A requester may reassert req in the same cycle its done is high; it is considered at the next IDLE edge.
- Reset (asynchronous, any state) sets:
  - state IDLE, cnt 0, ptr 0
  - ack0, ack1, done0, done1, res, busy, err all 0
  - dp_m..dp_q all 0
- A reset during SETTLE aborts the operation; no done is issued.

## Timing
- Grant edge E0: ack_k and busy are high, and the operand is on dp_*, in the cycle after E0.
- Operand stable on dp_* for exactly SETTLE_CYCLES clock periods before sampling.
- Sample edge E_S (S = SETTLE_CYCLES): done_k high and res valid in the cycle after E_S; busy low in that same cycle.
- Earliest next grant is E_{S+1}. Throughput is one operation per S+1 cycles. With a 10-unit clock and the default S=2, the worst path delay of 15 is covered.
- ack and done are single-cycle pulses; at most one ack and one done are high in any cycle.

## Configuration
- AND4_ARB_CHECK_EN defined:
  - On each sample edge, err <= (dp_out != &{dp_m,dp_n,dp_p,dp_q}).
  - err is a one-cycle pulse aligned with done.
- AND4_ARB_CHECK_EN undefined:
  - The check logic is absent and err is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then req0=1, data0=4'b1111, S=2 -> ack0 in cycle after E0; dp_*=1111; done0=1 and res=1 in the cycle after E2; busy low then.
- req1=1 with data1=4'b1011 -> res=0, done1 pulse, done0 stays 0.
- req0 and req1 high together, both held through two operations -> grant order 0 then 1, second ack at E3, res per operand, no ack while busy.
- req1 asserted mid-SETTLE of a req0 operation -> ack1 only at the first IDLE edge after done0; dp_* unchanged until then.
- rst_n low during SETTLE -> all outputs 0 immediately, no done; a fresh req after release is served normally with ptr=0.
- With AND4_ARB_CHECK_EN, datapath model forced to return 0 for 1111 -> err pulses with done; without the macro err stays 0.
